// File: rtl/readout_scan_n_if.sv
// Host/slot-bus bundle for readout_scan_n: scan control, slot address/data bus, host readback.
// slave = the scanner, master = the host/slot-bus side.
interface readout_scan_n_if #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int DAW = 8
);
    logic          start;
    logic [DW-1:0] thresh;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          sel;
    logic [DAW-1:0] haddr;
    logic          busy;
    logic [AW+DW-1:0] hdata;
    logic [DAW:0]  hnhit;
    logic          ovf;
    logic          done;

    modport slave (
        input  start, thresh, data, sel, haddr,
        output addr, busy, hdata, hnhit, ovf, done
    );

    modport master (
        output start, thresh, data, sel, haddr,
        input  addr, busy, hdata, hnhit, ovf, done
    );
endinterface

// File: rtl/readout_scan_n.sv
// Pipelined slot scanner: one slot per clock, bus-latency compensated, hits stored as {slot, value}.
// Optional READOUT_ZERO_SUPPRESS_EN: hit means data > thresh (latched at start) instead of data != 0.
module readout_scan_n #(
    parameter int N_SLOTS = 256,
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int DEPTH   = 256,
    parameter int DAW     = 8,
    parameter int BUS_LAT = 0
) (
    input logic             clk,
    input logic             rst_n,
    readout_scan_n_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    addr_q;
    logic [2:0]       drain_cnt;
    logic             busy_int, done_int, start_ok, last_slot;
    logic [DAW:0]     cnt;
    logic             ovf_q, hit, full;
    logic [AW+DW-1:0] buf_mem [DEPTH];
    logic [AW+DW-1:0] hdata_q;
    logic             vld_tap;
    logic [AW-1:0]    slot_tap;

    assign last_slot = (addr_q == AW'(N_SLOTS - 1));
    assign start_ok  = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_int  = 1'b0;
        done_int  = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = SCAN;
            SCAN: begin
                busy_int = 1'b1;
                if (last_slot) state_nxt = (BUS_LAT == 0) ? FIN : DRAIN;
            end
            DRAIN: begin
                busy_int = 1'b1;
                if (drain_cnt == 3'(BUS_LAT - 1)) state_nxt = FIN;
            end
            FIN: begin
                done_int  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address parks at 0 outside SCAN, so the first SCAN cycle already drives slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            drain_cnt <= '0;
        end else begin
            addr_q    <= (state == SCAN && !last_slot) ? addr_q + AW'(1) : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : '0;
        end
    end

    // Slot number and valid follow the address down the bus latency so data lines up with its slot.
    generate
        if (BUS_LAT == 0) begin : g_nolat
            assign vld_tap  = (state == SCAN);
            assign slot_tap = addr_q;
        end else begin : g_lat
            logic [BUS_LAT:1]         vld_pipe;
            logic [BUS_LAT:1][AW-1:0] slot_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe  <= '0;
                    slot_pipe <= '0;
                end else begin
                    vld_pipe[1]  <= (state == SCAN);
                    slot_pipe[1] <= addr_q;
                    for (int i = 2; i <= BUS_LAT; i++) begin
                        vld_pipe[i]  <= vld_pipe[i-1];
                        slot_pipe[i] <= slot_pipe[i-1];
                    end
                end
            end
            assign vld_tap  = vld_pipe[BUS_LAT];
            assign slot_tap = slot_pipe[BUS_LAT];
        end
    endgenerate

`ifdef READOUT_ZERO_SUPPRESS_EN
    logic [DW-1:0] thr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        thr <= '0;
        else if (start_ok) thr <= bus.thresh;
    end
    assign hit = vld_tap && (bus.data > thr);
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;
    assign hit = vld_tap && (bus.data != '0);
`endif

    assign full = (cnt == (DAW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (hit) begin
            if (full) ovf_q <= 1'b1;
            else      cnt   <= cnt + (DAW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (hit && !full) buf_mem[cnt[DAW-1:0]] <= {slot_tap, bus.data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hdata_q <= '0;
        else        hdata_q <= buf_mem[bus.haddr];
    end

    assign bus.addr  = addr_q;
    assign bus.busy  = bus.sel & busy_int;
    assign bus.hnhit = bus.sel ? cnt : '0;
    assign bus.hdata = bus.sel ? hdata_q : '0;
    assign bus.ovf   = ovf_q;
    assign bus.done  = done_int;
endmodule

// File: tb/tb_readout_scan_n.sv
// Bench for readout_scan_n: a default instance and a BUS_LAT=2 / DEPTH=4 instance share one host,
// both checked against a hit list computed from the slot image.
module tb_readout_scan_n;
    localparam int AW = 8, DW = 16, NS = 256;
    localparam int D0 = 256, DA0 = 8;
    localparam int D1 = 4, DA1 = 2, L1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          sel = 1'b1;
    logic [DW-1:0] thresh = '0;
    logic [7:0]    haddr = '0;
    logic [DW-1:0] mem [NS];
    logic [AW-1:0] a1_d1, a1_d2;
    logic [AW+DW-1:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    readout_scan_n_if #(.AW(AW), .DW(DW), .DAW(DA0)) bus0 ();
    readout_scan_n_if #(.AW(AW), .DW(DW), .DAW(DA1)) bus1 ();

    assign bus0.start  = start;
    assign bus0.thresh = thresh;
    assign bus0.sel    = sel;
    assign bus0.haddr  = haddr;
    assign bus0.data   = mem[bus0.addr];
    assign bus1.start  = start;
    assign bus1.thresh = thresh;
    assign bus1.sel    = sel;
    assign bus1.haddr  = haddr[DA1-1:0];
    assign bus1.data   = mem[a1_d2];

    // two-cycle slot bus seen by the BUS_LAT=2 instance
    always @(posedge clk) begin
        a1_d1 <= bus1.addr;
        a1_d2 <= a1_d1;
    end

    readout_scan_n #(.N_SLOTS(NS), .AW(AW), .DW(DW), .DEPTH(D0), .DAW(DA0), .BUS_LAT(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    readout_scan_n #(.N_SLOTS(NS), .AW(AW), .DW(DW), .DEPTH(D1), .DAW(DA1), .BUS_LAT(L1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Without zero suppression the effective threshold is zero, i.e. any nonzero word is a hit.
    function automatic bit is_hit(input logic [DW-1:0] v, input logic [DW-1:0] t);
        logic [DW-1:0] lim;
`ifdef READOUT_ZERO_SUPPRESS_EN
        lim = t;
`else
        lim = t & '0;
`endif
        return v > lim;
    endfunction

    task automatic load_plan();
        for (int s = 0; s < NS; s++) mem[s] = '0;
        mem[0] = 16'd100;   mem[1] = 16'd2000;  mem[2] = 16'd5555;
        mem[3] = 16'd500;   mem[254] = 16'd10000; mem[255] = 16'd150;
    endtask

    task automatic load_rand(input int pct);
        for (int s = 0; s < NS; s++)
            mem[s] = ($urandom_range(99) < pct) ? DW'($urandom_range(1, 4000)) : '0;
    endtask

    task automatic run_scan(input bit sel_on, input bit poke, input logic [DW-1:0] thr);
        int bc0 = 0, bc1 = 0, dc0 = 0, dc1 = 0, n, n0, n1, c;
        bit gate = 1'b0;
        exp_q.delete();
        for (int s = 0; s < NS; s++)
            if (is_hit(mem[s], thr)) exp_q.push_back({s[AW-1:0], mem[s]});
        n  = exp_q.size();
        n0 = (n > D0) ? D0 : n;
        n1 = (n > D1) ? D1 : n;

        @(negedge clk);
        sel = sel_on; thresh = thr; haddr = '0; start = 1'b1;
        c = 0;
        while (c < 700 && !(dc0 > 0 && dc1 > 0)) begin
            @(negedge clk);
            start = poke && (c == 10);
            if (c == 20) thresh = DW'($urandom);
            if (c == 0) begin
                chk("ovf_clr0", bus0.ovf, 0);
                chk("ovf_clr1", bus1.ovf, 0);
            end
            bc0 += int'(bus0.busy);
            bc1 += int'(bus1.busy);
            dc0 += int'(bus0.done);
            dc1 += int'(bus1.done);
            if (bus0.busy || bus1.busy || bus0.hnhit != 0 || bus1.hnhit != 0 ||
                bus0.hdata != 0 || bus1.hdata != 0) gate = 1'b1;
            c++;
        end
        if (dc0 == 0 || dc1 == 0) chk("done_timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            dc0 += int'(bus0.done);
            dc1 += int'(bus1.done);
        end
        if (sel_on) begin
            chk("busy_len0", bc0, NS);
            chk("busy_len1", bc1, NS + L1);
        end else begin
            chk("sel_gate", gate, 0);
        end
        chk("done_cnt0", dc0, 1);
        chk("done_cnt1", dc1, 1);

        sel = 1'b1;
        @(negedge clk);
        chk("hnhit0", bus0.hnhit, n0);
        chk("hnhit1", bus1.hnhit, n1);
        chk("ovf0", bus0.ovf, n > D0);
        chk("ovf1", bus1.ovf, n > D1);
        for (int i = 0; i < n0; i++) begin
            haddr = 8'(i);
            @(negedge clk);
            chk($sformatf("hdata0[%0d]", i), bus0.hdata, exp_q[i]);
            if (i < n1) chk($sformatf("hdata1[%0d]", i), bus1.hdata, exp_q[i]);
        end
    endtask

    task automatic reset_mid(input int at);
        @(negedge clk);
        sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        chk("busy_pre_rst", bus0.busy, 1);
        chk("addr_pre_rst", bus0.addr, at - 1);
        rst_n = 1'b0;
        #1;
        chk("rst_addr0", bus0.addr, 0);
        chk("rst_busy0", bus0.busy, 0);
        chk("rst_hnhit0", bus0.hnhit, 0);
        chk("rst_addr1", bus1.addr, 0);
        chk("rst_busy1", bus1.busy, 0);
        chk("rst_hnhit1", bus1.hnhit, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        load_plan();
        rst_n = 1'b0; sel = 1'b1;
        repeat (2) @(negedge clk);
        chk("init_addr", bus0.addr, 0);
        chk("init_busy", bus0.busy, 0);
        chk("init_hdata", bus0.hdata, 0);
        chk("init_hnhit", bus0.hnhit, 0);
        chk("init_ovf", bus0.ovf, 0);
        chk("init_done", bus0.done, 0);
        chk("init_hnhit1", bus1.hnhit, 0);
        chk("init_ovf1", bus1.ovf, 0);
        rst_n = 1'b1;

        run_scan(1'b1, 1'b0, 16'd400);
        run_scan(1'b1, 1'b1, 16'd400);
        run_scan(1'b0, 1'b0, 16'd400);
        reset_mid(100);
        run_scan(1'b1, 1'b0, 16'd400);

        for (int s = 0; s < NS; s++) mem[s] = DW'($urandom_range(1, 65535));
        run_scan(1'b1, 1'b0, '0);
        for (int s = 0; s < NS; s++) mem[s] = (s < 4) ? DW'(s + 1) : '0;
        run_scan(1'b1, 1'b0, '0);
        for (int s = 0; s < NS; s++) mem[s] = '0;
        run_scan(1'b1, 1'b0, '0);

        for (int r = 0; r < 5; r++) begin
            load_rand($urandom_range(1, 60));
            run_scan(1'b1, 1'b0, DW'($urandom_range(0, 2000)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
